wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
Writeback stage driving the register file write port (rd_addr, wr_data, wr_en). Arbitrates between an ALU result stream and a load-return stream, and sign/zero-extends load data. Tracks a pending-write scoreboard for the issue stage. Optionally forwards the in-flight write to the register-file read ports.

Parameters:
XLEN, 32, datapath width
STARVE_LIMIT, 4, consecutive stalled ALU cycles before ALU gets forced priority (1..15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle when high with alu_valid
alu_rd  input  5  ALU destination register
alu_result  input  XLEN  ALU result
mem_valid  input  1  load return valid
mem_ready  output  1  load return accepted when high with mem_valid
mem_rd  input  5  load destination register
mem_rdata  input  XLEN  raw aligned memory word
mem_funct3  input  3  load type
mem_addr_lo  input  2  load byte offset
issue_valid  input  1  instruction issued that will write issue_rd
issue_rd  input  5  destination of issued instruction
pending  output  32  scoreboard, bit r = write to r outstanding
rd_addr  output  5  register file write address
wr_data  output  XLEN  register file write data
wr_en  output  1  register file write enable
rs1_addr, rs2_addr  input  5 each  decode read addresses
rf_rs1_data, rf_rs2_data  input  XLEN each  raw register file read data
rs1_data, rs2_data  output  XLEN each  read data to decode

Behaviour:
- Reset (async, rst=1): rd_addr=0, wr_data=0, wr_en=0, pending=0, starve counter=0. Ready outputs follow the combinational rules below.
- Arbitration (combinational; ready never depends on the requester's own valid):
  - Default: mem has priority, so mem_ready=1 and alu_ready=!mem_valid.
  - Override when starve counter == STARVE_LIMIT: alu_ready=1, mem_ready=0.
- Starve counter:
  - Increments when alu_valid && !alu_ready.
  - Clears to 0 when ALU is accepted or alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Accept: at most one source per cycle. The accepted result is registered into rd_addr/wr_data.
  - wr_en=1 in the next cycle only if the accepted rd != 0.
  - rd=0 results are consumed and dropped: wr_en=0 and pending is unchanged.
  - With no accept, wr_en=0 next cycle and rd_addr/wr_data hold.
- Latency: accept at posedge N -> wr_en high during cycle N+1 -> register file updates at posedge N+1. Raw register file read shows the new value from cycle N+2.
- Load extraction (byte = mem_rdata[8*addr_lo+7 : 8*addr_lo], half = mem_addr_lo[1] ? [31:16] : [15:0]):
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - 010 and all other codes: full word
  - Halfword with addr_lo=1 or 3 uses addr_lo[1] only; no misalignment fault.
- Scoreboard:
  - issue_valid sets pending[issue_rd] (ignored for rd=0).
  - A cycle with wr_en=1 clears pending[rd_addr].
  - Set and clear of the same bit in one cycle: set wins.
  - pending[0] is always 0.
  - The issue stage must not issue to a pending rd; this block does not check it.
- Reset mid-operation: the in-flight write is lost (wr_en=0), pending clears, and no stale write appears after reset release.

Optional Feature:
WB_BYPASS_EN
- Defined: rs1_data = wr_data when wr_en && rs1_addr == rd_addr && rd_addr != 0, else rf_rs1_data; same rule for rs2. Decode sees a result in cycle N+1.
- Undefined: rs1_data = rf_rs1_data and rs2_data = rf_rs2_data, pure passthrough.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_result=0x12345678 at cycle 0 -> alu_ready=1; cycle 1 wr_en=1, rd_addr=5, wr_data=0x12345678; cycle 2 wr_en=0.
- Loads: mem_rdata=0x80F0_7F81 with addr_lo=0 LB -> 0xFFFFFF81; addr_lo=1 LBU -> 0x0000007F; addr_lo=2 LH -> 0xFFFF80F0; addr_lo=0 LHU -> 0x00007F81; funct3=010 -> 0x80F07F81.
- Starvation: mem_valid and alu_valid held high for 10 cycles, STARVE_LIMIT=4 -> 4 mem accepts, then 1 ALU accept in cycle 5 (mem_ready=0), then mem resumes.
- x0 and scoreboard: issue_valid with issue_rd=7 -> pending[7]=1; ALU result for rd=7 accepted -> pending[7] clears the cycle after wr_en. Result to rd=0 -> wr_en stays 0. Issue of rd=9 in the same cycle as the writeback of rd=9 -> pending[9] stays 1.
- Async reset: rst asserted mid-cycle with an accept registered -> wr_en, pending, rd_addr and wr_data go 0 immediately; starve counter=0 after release.
- Bypass (WB_BYPASS_EN): wr_en=1, rd_addr=3, wr_data=0xAA, rs1_addr=3, rf_rs1_data=0x11 -> rs1_data=0xAA. With rs1_addr=0 or macro undefined -> rs1_data=0x11.

Source files
------------

// File: rtl/wb_unit.sv
// wb_unit: writeback stage. Arbitrates ALU results and load returns onto the
// register file write port, extracts load data with sign/zero extension, and
// keeps a pending-write scoreboard for the issue stage.
// Build option: define WB_BYPASS_EN to forward the in-flight write to the
// register-file read ports. Otherwise the read data passes straight through.
module wb_unit #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_result,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [2:0]      mem_funct3,
   input  logic [1:0]      mem_addr_lo,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   output logic [31:0]     pending,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] wr_data,
   output logic            wr_en,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rf_rs1_data,
   input  logic [XLEN-1:0] rf_rs2_data,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data
);

   logic [3:0]      starve_cnt;
   logic            force_alu;
   logic            alu_acc;
   logic            mem_acc;
   logic            wb_fire;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] load_data;
   logic [31:0]     ld_shifted;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     pending_nxt;

   // Arbitration: loads win unless the ALU has been stalled long enough.
   // Ready never looks at the requester's own valid.
   always_comb begin
      force_alu = (starve_cnt == 4'(STARVE_LIMIT));
      mem_ready = !force_alu;
      alu_ready = force_alu || !mem_valid;
      alu_acc   = alu_valid && alu_ready;
      mem_acc   = mem_valid && mem_ready;
      wb_fire   = alu_acc || mem_acc;
      wb_rd     = mem_acc ? mem_rd : alu_rd;
      wb_data   = mem_acc ? load_data : alu_result;
   end

   // Load extraction: select byte/half by offset, then sign or zero extend.
   always_comb begin
      ld_shifted = mem_rdata[31:0] >> {mem_addr_lo, 3'b000};
      ld_byte    = ld_shifted[7:0];
      ld_half    = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (mem_funct3)
         3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
         default: load_data = mem_rdata;
      endcase
   end

   // Starve counter: counts consecutive stalled ALU cycles, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (alu_valid && !alu_ready) begin
         if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      end else begin
         starve_cnt <= '0;
      end
   end

   // Writeback register: capture accepted result; x0 writes are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr <= '0;
         wr_data <= '0;
         wr_en   <= 1'b0;
      end else begin
         wr_en <= wb_fire && (wb_rd != 5'd0);
         if (wb_fire) begin
            rd_addr <= wb_rd;
            wr_data <= wb_data;
         end
      end
   end

   // Scoreboard next state: clear on writeback, then set on issue so set wins.
   always_comb begin
      pending_nxt = pending;
      if (wr_en) pending_nxt[rd_addr] = 1'b0;
      if (issue_valid) pending_nxt[issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

`ifdef WB_BYPASS_EN
   // Forward the in-flight write to decode one cycle before the file has it.
   always_comb begin
      rs1_data = (wr_en && rs1_addr == rd_addr && rd_addr != 5'd0) ? wr_data : rf_rs1_data;
      rs2_data = (wr_en && rs2_addr == rd_addr && rd_addr != 5'd0) ? wr_data : rf_rs2_data;
   end
`else
   // Read data passes straight through.
   always_comb begin
      rs1_data = rf_rs1_data;
      rs2_data = rf_rs2_data;
   end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit. Expected register-file writes are queued
// when stimulus is driven and compared when wr_en is observed.
module tb_wb_unit;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_result;
   logic            mem_valid, mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_rdata;
   logic [2:0]      mem_funct3;
   logic [1:0]      mem_addr_lo;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [31:0]     pending;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] wr_data;
   logic            wr_en;
   logic [4:0]      rs1_addr, rs2_addr;
   logic [XLEN-1:0] rf_rs1_data, rf_rs2_data, rs1_data, rs2_data;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;
   wb_t exp_q[$];

   wb_unit #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
      .rd_addr(rd_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .rs1_data(rs1_data), .rs2_data(rs2_data)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every write must match the oldest expected one.
   always @(negedge clk) begin
      wb_t e;
      if (rst === 1'b0 && wr_en === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: rd_addr=%0d wr_data=%h, required no write", rd_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_addr !== e.rd || wr_data !== e.data) begin
               errors++;
               $display("FAIL write_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        rd_addr, wr_data, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
      vectors++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h, required 0", pending); end
      vectors++; if (rd_addr !== 5'd0)  begin errors++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
      vectors++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
      vectors++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got mem=%b alu=%b, required 1/1", mem_ready, alu_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alu();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h12345678;
      exp_q.push_back('{rd: 5'd5, data: 32'h12345678});
      @(negedge clk);
      vectors++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b, required 1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      vectors++; if (wr_en !== 1'b1) begin errors++; $display("FAIL alu_wr_en_n1: got %b, required 1", wr_en); end
      tick();
      @(negedge clk);
      vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alu_wr_en_n2: got %b, required 0", wr_en); end
      tick();
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL alu_missing: got %0d pending writes, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3[7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b100};
      logic [1:0]  lo[7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd3};
      logic [31:0] ex[7] = '{32'hFFFFFF81, 32'h0000007F, 32'hFFFF80F0, 32'h00007F81,
                             32'h80F07F81, 32'hFFFF80F0, 32'h00000080};
      mem_rdata = 32'h80F07F81;
      for (int i = 0; i < 7; i++) begin
         mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_funct3 = f3[i]; mem_addr_lo = lo[i];
         exp_q.push_back('{rd: 5'(10 + i), data: ex[i]});
         @(negedge clk);
         vectors++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d]: got %b, required 1", i, mem_ready); end
         tick();
      end
      mem_valid = 1'b0;
      tick(); tick();
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL load_missing: got %0d pending writes, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_starve();
      int cnt = 0;
      logic exp_alu;
      alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd20; mem_rd = 5'd21; mem_funct3 = 3'b010;
      for (int c = 1; c <= 10; c++) begin
         alu_result = 32'h200 + c;
         mem_rdata  = 32'h100 + c;
         exp_alu = (cnt == 4);
         if (exp_alu) begin
            exp_q.push_back('{rd: 5'd20, data: 32'h200 + c});
            cnt = 0;
         end else begin
            exp_q.push_back('{rd: 5'd21, data: 32'h100 + c});
            cnt++;
         end
         @(negedge clk);
         vectors++;
         if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
            errors++;
            $display("FAIL starve_ready[%0d]: got alu=%b mem=%b, required alu=%b mem=%b",
                     c, alu_ready, mem_ready, exp_alu, !exp_alu);
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick(); tick();
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL starve_missing: got %0d pending writes, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      vectors++; if (pending !== 32'h80) begin errors++; $display("FAIL sb_set7: got %h, required 00000080", pending); end
      alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h77;
      exp_q.push_back('{rd: 5'd7, data: 32'h77});
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      vectors++; if (pending !== 32'h80) begin errors++; $display("FAIL sb_hold7: got %h, required 00000080", pending); end
      tick();
      @(negedge clk);
      vectors++; if (pending !== 32'h0) begin errors++; $display("FAIL sb_clear7: got %h, required 0", pending); end
      alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hDEAD;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      alu_valid = 1'b0; issue_valid = 1'b0;
      @(negedge clk);
      vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en: got %b, required 0", wr_en); end
      vectors++; if (pending !== 32'h0) begin errors++; $display("FAIL x0_pending: got %h, required 0", pending); end
      alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h99;
      exp_q.push_back('{rd: 5'd9, data: 32'h99});
      tick();
      alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      vectors++; if (pending !== 32'h200) begin errors++; $display("FAIL sb_set_wins9: got %h, required 00000200", pending); end
      alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h98;
      exp_q.push_back('{rd: 5'd9, data: 32'h98});
      tick();
      alu_valid = 1'b0;
      tick();
      @(negedge clk);
      vectors++; if (pending !== 32'h0) begin errors++; $display("FAIL sb_clear9: got %h, required 0", pending); end
      tick();
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_missing: got %0d pending writes, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_async_reset();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h1;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_funct3 = 3'b010; mem_rdata = 32'h5555;
      tick(); tick();
      mem_rd = 5'd14; issue_valid = 1'b1; issue_rd = 5'd13;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
      vectors++; if (wr_en !== 1'b1 || pending !== 32'h2000) begin
         errors++; $display("FAIL ar_pre: got wr_en=%b pending=%h, required 1/00002000", wr_en, pending);
      end
      #1 rst = 1'b1;
      #1;
      vectors++; if (wr_en !== 1'b0 || pending !== 32'h0 || rd_addr !== 5'd0 || wr_data !== 32'h0) begin
         errors++; $display("FAIL ar_clear: got wr_en=%b pending=%h rd=%0d data=%h, required all 0",
                            wr_en, pending, rd_addr, wr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      @(negedge clk);
      vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ar_stale: got wr_en=%b, required 0", wr_en); end
      tick();
      alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd0; mem_rd = 5'd0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         vectors++; if (alu_ready !== (c == 5)) begin
            errors++; $display("FAIL ar_starve[%0d]: got alu_ready=%b, required %b", c, alu_ready, (c == 5));
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      logic [31:0] exp_fwd;
`ifdef WB_BYPASS_EN
      exp_fwd = 32'hAA;
`else
      exp_fwd = 32'h11;
`endif
      alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'hAA;
      exp_q.push_back('{rd: 5'd3, data: 32'hAA});
      rs1_addr = 5'd3; rf_rs1_data = 32'h11; rs2_addr = 5'd3; rf_rs2_data = 32'h22;
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      vectors++; if (rs1_data !== exp_fwd) begin errors++; $display("FAIL byp_rs1: got %h, required %h", rs1_data, exp_fwd); end
      vectors++; if (rs2_data !== ((exp_fwd == 32'hAA) ? 32'hAA : 32'h22)) begin
         errors++; $display("FAIL byp_rs2: got %h", rs2_data);
      end
      rs1_addr = 5'd0;
      #1;
      vectors++; if (rs1_data !== 32'h11) begin errors++; $display("FAIL byp_rs1_x0: got %h, required 00000011", rs1_data); end
      tick();
      rs1_addr = 5'd3;
      @(negedge clk);
      vectors++; if (rs1_data !== 32'h11) begin errors++; $display("FAIL byp_rs1_idle: got %h, required 00000011", rs1_data); end
      tick();
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL byp_missing: got %0d pending writes, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_rdata = '0; mem_funct3 = '0; mem_addr_lo = '0;
      issue_valid = 1'b0; issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
      test_reset();
      test_alu();
      test_loads();
      test_starve();
      test_scoreboard();
      test_async_reset();
      test_bypass();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
